// File: rtl/mem_loader_if.sv
// Byte-stream handshake into the boot loader: a source (master) offers bytes,
// the loader (slave) accepts them when in_ready is high.
interface mem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mem_loader.sv
// Boot-time program loader: packs a byte stream big-endian into 32-bit words,
// writes them sequentially to memory and holds the CPU in reset until the image is loaded.
module mem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 256,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_loader_if.slave           stream,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0]   MaxWords  = (ADDR_WIDTH + 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {StLoad, StWrite, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           partial_q, partial_d;
    logic                  last_q, last_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;

    logic                  accept;
    logic                  word_full;
    logic [31:0]           word_next;
    logic [ADDR_WIDTH:0]   count_inc;

    // in_ready_q is only ever high in StLoad, so it alone qualifies acceptance.
    assign accept    = stream.in_valid & in_ready_q;
    assign word_full = accept & ((lane_q == 2'd3) | stream.in_last);
    assign count_inc = word_count_q + 1'b1;

    always_comb begin
        word_next = partial_q;
        unique case (lane_q)
            2'd0: word_next = partial_q | {stream.in_data, 24'h0};
            2'd1: word_next = partial_q | {8'h0, stream.in_data, 16'h0};
            2'd2: word_next = partial_q | {16'h0, stream.in_data, 8'h0};
            2'd3: word_next = partial_q | {24'h0, stream.in_data};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLoad;
            lane_q       <= 2'd0;
            partial_q    <= 32'h0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= StartAddr;
            mem_wdata_q  <= 32'h0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            partial_q    <= partial_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad: begin
                if (word_full) state_d = StWrite;
            end
            StWrite: begin
                if (last_q)                     state_d = StDone;
                else if (count_inc == MaxWords) state_d = StErr;
                else                            state_d = StLoad;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        lane_d       = lane_q;
        partial_d    = partial_q;
        last_d       = last_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        in_ready_d   = (state_d == StLoad);

        if (state_q == StLoad && accept) begin
            partial_d = word_next;
            lane_d    = lane_q + 2'd1;
            last_d    = stream.in_last;
            if (word_full) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = StartAddr + word_count_q[ADDR_WIDTH-1:0];
                mem_wdata_d = word_next;
            end
        end

        if (state_q == StWrite) begin
            word_count_d = count_inc;
            partial_d    = 32'h0;
            lane_d       = 2'd0;
        end

        if (state_d == StDone) begin
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
        end
        if (state_d == StErr) error_d = 1'b1;
    end

    assign stream.in_ready = in_ready_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign cpu_reset       = cpu_reset_q;
    assign done            = done_q;
    assign error           = error_q;
    assign word_count      = word_count_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed images plus randomized images with gaps,
// compared against a word-level model of the expected memory writes and final status.
module tb_mem_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    img[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    always #5 clk = ~clk;

    mem_loader_if stream ();

    mem_loader #(
        .ADDR_WIDTH (AW),
        .MAX_WORDS  (MW),
        .START_ADDR (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stream     (stream),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe is logged, and the loader must not be ready while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            check_eq("ready_in_write", {63'h0, stream.in_ready}, 64'h0);
        end
    end

    task automatic idle_inputs();
        stream.in_valid = 1'b0;
        stream.in_data  = 8'($urandom);
        stream.in_last  = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", {63'h0, stream.in_ready}, 64'h0);
        check_eq("rst_mem_we", {63'h0, mem_we}, 64'h0);
        check_eq("rst_cpu_reset", {63'h0, cpu_reset}, 64'h1);
        check_eq("rst_done_err", {62'h0, done, error}, 64'h0);
        check_eq("rst_word_count", 64'(word_count), 64'h0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int waited = 0;
        stream.in_valid = 1'b1;
        stream.in_data  = d;
        stream.in_last  = last;
        @(negedge clk);
        while (stream.in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (stream.in_ready !== 1'b1) check_eq("accept_timeout", {63'h0, stream.in_ready}, 64'h1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic run_image(input int max_gap, input bit use_last);
        for (int i = 0; i < img.size(); i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            send_byte(img[i], use_last && (i == img.size() - 1));
        end
    endtask

    // Word-level reference: pad the image to whole words, pack big-endian, cap at capacity.
    task automatic check_result(input string name, input bit use_last);
        int n = img.size();
        int nwords;
        bit exp_err;
        logic [31:0] w;
        if (use_last) nwords = (n + 3) / 4;
        else nwords = (n / 4 > int'(MW)) ? int'(MW) : n / 4;
        exp_err = !use_last && (n / 4 >= int'(MW));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq({name, "_nwrites"}, 64'(got_addr.size()), 64'(nwords));
        for (int i = 0; i < nwords && i < got_addr.size(); i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = {w[23:0], ((4 * i + k) < n) ? img[4 * i + k] : 8'h00};
            end
            check_eq({name, "_addr"}, 64'(got_addr[i]), 64'(i));
            check_eq({name, "_data"}, 64'(got_data[i]), 64'(w));
        end
        check_eq({name, "_done"}, {63'h0, done}, {63'h0, use_last});
        check_eq({name, "_error"}, {63'h0, error}, {63'h0, exp_err});
        check_eq({name, "_cpu_reset"}, {63'h0, cpu_reset}, {63'h0, !use_last});
        check_eq({name, "_word_count"}, 64'(word_count), 64'(nwords));
        check_eq({name, "_in_ready"}, {63'h0, stream.in_ready},
                 {63'h0, !use_last && !exp_err});
    endtask

    task automatic load_test1();
        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    endtask

    initial begin
        idle_inputs();
        stream.in_valid = 1'b0;

        do_reset();
        load_test1();
        run_image(0, 1'b1);
        check_result("two_words", 1'b1);

        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        run_image(0, 1'b1);
        check_result("partial", 1'b1);

        do_reset();
        load_test1();
        run_image(3, 1'b1);
        check_result("gaps", 1'b1);

        // Capacity reached without in_last: error, then a further byte must be refused.
        do_reset();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        run_image(1, 1'b0);
        check_result("overflow", 1'b0);
        stream.in_valid = 1'b1;
        stream.in_data  = 8'h5A;
        stream.in_last  = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("overflow_refuse_ready", {63'h0, stream.in_ready}, 64'h0);
        check_eq("overflow_no_write", 64'(got_addr.size()), 64'(MW));
        check_eq("overflow_count", 64'(word_count), 64'(MW));
        check_eq("overflow_sticky", {61'h0, error, done, cpu_reset}, 64'h5);
        #1;
        idle_inputs();

        do_reset();
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        run_image(1, 1'b1);
        check_result("full_last", 1'b1);

        // Reset in the middle of the second word, then a fresh one-word image.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        repeat (2) @(posedge clk);
        do_reset();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_image(0, 1'b1);
        check_result("after_reset", 1'b1);

        // Stream is ignored once loading is done.
        got_addr.delete();
        got_data.delete();
        stream.in_valid = 1'b1;
        stream.in_data  = 8'hFF;
        stream.in_last  = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("done_no_write", 64'(got_addr.size()), 64'h0);
        check_eq("done_count", 64'(word_count), 64'h1);
        check_eq("done_stable", {61'h0, done, cpu_reset, error}, 64'h4);
        #1;
        idle_inputs();

        for (int t = 0; t < 20; t++) begin
            int len = int'($urandom_range(16, 1));
            do_reset();
            img.delete();
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            run_image(2, 1'b1);
            check_result("random", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
